sayeh_mem_arbiter: RTL and testbench
====================================

Name: sayeh_mem_arbiter

Overview:
- Two-port arbiter/sequencer that shares the single-port MemIP block RAM between the Sayeh CPU bus (port 0) and a secondary bus master (port 1: loader/DMA).
- Converts level-held requester read/write strobes into the memory's single-cycle nd/we strobes.
- Waits for rdy on reads, with a timeout, and returns a one-cycle ready pulse to the served requester.
- Placed between Sayeh/loader and MemIP in the processor top level.

Parameters:
- AW, 10: memory address width; low AW bits of the 16-bit request address are used.
- DW, 16: data width.
- TIMEOUT, 64: maximum cycles in RD_WAIT before abort.
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock, all logic on rising edge
- ExternalReset_n  in  1  synchronous, active-low reset
- p0_rd  in  1  port 0 read request, held until p0_ready
- p0_wr  in  1  port 0 write request, held until p0_ready
- p0_addr  in  16  port 0 address
- p0_din  in  DW  port 0 write data
- p0_dout  out  DW  port 0 read data, valid with p0_ready
- p0_ready  out  1  port 0 one-cycle completion pulse
- p1_rd, p1_wr, p1_addr, p1_din, p1_dout, p1_ready  same as port 0, for port 1
- mem_addr  out  AW  address to MemIP
- mem_din  out  DW  write data to MemIP
- mem_nd  out  1  one-cycle read strobe
- mem_we  out  1  one-cycle write strobe
- mem_dout  in  DW  read data from MemIP
- mem_rdy  in  1  read data valid
- busy  out  1  high in any state except IDLE
- owner  out  1  port currently or last granted
- timeout_err  out  1  sticky, set on read timeout

Behaviour:
- Reset (ExternalReset_n=0 at a clk edge):
  - state=IDLE; all outputs 0; rr pointer=port 0; timeout counter=0; timeout_err=0.
  - Reset mid-transaction aborts it with no ready pulse. A late mem_rdy is ignored.
- States: IDLE, ISSUE, RD_WAIT, DONE.
- IDLE:
  - A port is requesting when rd|wr is high.
  - One requester: grant it.
  - Both requesting, FIXED_PRIO=1: port 0 wins.
  - Both requesting, FIXED_PRIO=0: the port other than the last served wins; rr pointer updates on grant.
  - On grant, register addr[AW-1:0], din, op and owner, then go to ISSUE.
  - rd and wr both high on one port: treated as a write.
- ISSUE (exactly one cycle):
  - Read: mem_nd=1; go to RD_WAIT.
  - Write: mem_we=1 with mem_din driven; go to DONE.
  - mem_addr stays stable from ISSUE through RD_WAIT.
- RD_WAIT:
  - On mem_rdy: capture mem_dout into the owner's dout register; go to DONE.
  - The counter increments each cycle. At TIMEOUT cycles without rdy: dout=all ones, timeout_err=1; go to DONE.
  - mem_rdy in the same cycle the counter hits TIMEOUT: rdy wins, no error.
- DONE (one cycle):
  - Owner's ready=1; the other port's ready stays 0. Then go to IDLE.
  - The requester must sample its rd/wr low by the cycle after ready. Otherwise the request is treated as a new one.
- Latency:
  - Request first seen in IDLE at cycle N: mem_nd/mem_we at N+1.
  - Write ready at N+2.
  - Read ready at the cycle after mem_rdy (minimum N+3 if rdy arrives at N+2).
- pX_dout holds its last value until that port's next read completes.
- The non-owner may change its request at any time. It is sampled only in IDLE.
- mem_nd and mem_we are never high together and never high outside ISSUE.
- Throughput: one transaction per 3 cycles (write) or 3+L cycles (read latency L); no pipelining.

Decomposition:
- Shared package sayeh_mem_pkg holds:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_RD_WAIT, ST_DONE (2 bits);
  - default widths AW_DEF=10, DW_DEF=16;
  - TIMEOUT_DATA = 16'hFFFF.
- One natural sub-module, sayeh_rr_pick: a 2-requester round-robin/fixed-priority grant with a last-served pointer.

Test Plan:
- Single read: p0_rd=1, p0_addr=0x0005, memory rdy 2 cycles after nd, word 0x1234 → mem_nd pulse with mem_addr=0x005; p0_ready single pulse; p0_dout=0x1234; busy low afterward.
- Write then read: p1_wr addr 0x03FF data 0xBEEF, then p1_rd same addr → mem_we pulse with mem_din=0xBEEF; p1_ready 2 cycles after request; readback 0xBEEF.
- Contention with FIXED_PRIO=0: p0_rd and p1_rd held together 4 transactions → grants alternate 0,1,0,1. With FIXED_PRIO=1, port 0 served first each time it requests.
- Timeout with TIMEOUT=8, mem_rdy tied 0: p0_rd → ready after 8 RD_WAIT cycles; p0_dout=0xFFFF; timeout_err=1 stays set until reset.
- Reset mid-read: ExternalReset_n=0 during RD_WAIT, then mem_rdy → no ready pulse; state IDLE; outputs 0; error clear.
- Address truncation and rd+wr: p0_addr=0xFC12, both rd and wr set → mem_we with mem_addr=0x012 (write precedence); mem_nd never asserted.

Source files
------------

// File: rtl/sayeh_mem_pkg.sv
// Shared types and constants for the Sayeh memory arbiter.
// Imported by the arbiter top and its grant picker.
package sayeh_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 16;

   localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/sayeh_rr_pick.sv
// Two-requester grant picker, round-robin or fixed priority.
// Holds a pointer to the port that wins the next tie.
module sayeh_rr_pick
   import sayeh_mem_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic       gnt_valid,
   output logic       gnt_port
);

   logic prio;

   always_comb begin
      gnt_valid = |req;
      gnt_port  = 1'b0;
      unique case (1'b1)
         (req == 2'b11): gnt_port = (FIXED_PRIO != 0) ? 1'b0 : prio;
         (req == 2'b10): gnt_port = 1'b1;
         default:        gnt_port = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (take && gnt_valid) begin
         prio <= ~gnt_port;
      end
   end

endmodule

// File: rtl/sayeh_mem_arbiter.sv
// Shares the single-port MemIP RAM between the CPU bus and a
// secondary master, turning held strobes into one-cycle nd/we.
module sayeh_mem_arbiter
   import sayeh_mem_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int TIMEOUT    = 64,
   parameter int FIXED_PRIO = 0
) (
   input  logic          clk,
   input  logic          ExternalReset_n,
   input  logic          p0_rd,
   input  logic          p0_wr,
   input  logic [15:0]   p0_addr,
   input  logic [DW-1:0] p0_din,
   output logic [DW-1:0] p0_dout,
   output logic          p0_ready,
   input  logic          p1_rd,
   input  logic          p1_wr,
   input  logic [15:0]   p1_addr,
   input  logic [DW-1:0] p1_din,
   output logic [DW-1:0] p1_dout,
   output logic          p1_ready,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_nd,
   output logic          mem_we,
   input  logic [DW-1:0] mem_dout,
   input  logic          mem_rdy,
   output logic          busy,
   output logic          owner,
   output logic          timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0] TO_DATA = {DW{1'b1}};

   state_t        state;
   state_t        state_nxt;
   logic          op_wr;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] din_q;
   logic [CW-1:0] cnt;
   logic [1:0]    req;
   logic          gnt_valid;
   logic          gnt_port;
   logic          rd_hit;
   logic          rd_to;
   logic          unused_addr_hi;

   assign unused_addr_hi = ^{p0_addr[15:AW], p1_addr[15:AW]};

   assign req = {p1_rd | p1_wr, p0_rd | p0_wr};

   sayeh_rr_pick #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_pick (
      .clk      (clk),
      .rst_n    (ExternalReset_n),
      .req      (req),
      .take     (state == ST_IDLE),
      .gnt_valid(gnt_valid),
      .gnt_port (gnt_port)
   );

   // rdy takes precedence over an expiring counter
   assign rd_hit = (state == ST_RD_WAIT) && mem_rdy;
   assign rd_to  = (state == ST_RD_WAIT) && !mem_rdy
                && (cnt == CW'(TIMEOUT - 1));

   assign mem_addr = addr_q;
   assign mem_din  = din_q;

   always_comb begin
      state_nxt = state;
      mem_nd    = 1'b0;
      mem_we    = 1'b0;
      p0_ready  = 1'b0;
      p1_ready  = 1'b0;
      busy      = (state != ST_IDLE);
      unique case (state)
         ST_IDLE: begin
            if (gnt_valid) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            mem_we    = op_wr;
            mem_nd    = ~op_wr;
            state_nxt = op_wr ? ST_DONE : ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (rd_hit || rd_to) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            p0_ready  = ~owner;
            p1_ready  = owner;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!ExternalReset_n) begin
         state       <= ST_IDLE;
         op_wr       <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         owner       <= 1'b0;
         cnt         <= '0;
         p0_dout     <= '0;
         p1_dout     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && gnt_valid) begin
            owner  <= gnt_port;
            op_wr  <= gnt_port ? p1_wr : p0_wr;
            addr_q <= gnt_port ? p1_addr[AW-1:0]
                               : p0_addr[AW-1:0];
            din_q  <= gnt_port ? p1_din : p0_din;
         end
         if (state == ST_RD_WAIT) cnt <= cnt + 1'b1;
         else                     cnt <= '0;
         if (rd_hit || rd_to) begin
            if (owner) p1_dout <= rd_hit ? mem_dout : TO_DATA;
            else       p0_dout <= rd_hit ? mem_dout : TO_DATA;
         end
         if (rd_to) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sayeh_mem_arbiter.sv
// Directed bench for sayeh_mem_arbiter: round-robin instance
// with a RAM model, plus a fixed-priority instance.
module tb_sayeh_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p0_rd = 0, p0_wr = 0, p1_rd = 0, p1_wr = 0;
   logic [15:0] p0_addr = 0, p1_addr = 0, p0_din = 0, p1_din = 0;
   logic [15:0] p0_dout, p1_dout, mem_din, mem_dout;
   logic        p0_ready, p1_ready, mem_nd, mem_we, mem_rdy;
   logic [9:0]  mem_addr;
   logic        busy, owner, timeout_err;

   logic        f_p0_wr = 0, f_p1_wr = 0;
   logic [15:0] f_p0_dout, f_p1_dout, f_mem_din;
   logic        f_p0_ready, f_p1_ready, f_mem_nd, f_mem_we;
   logic [9:0]  f_mem_addr;
   logic        f_busy, f_owner, f_terr;

   int checks = 0;
   int failures = 0;

   logic [15:0] mem [0:1023];
   logic        pend = 1'b0;
   int          lat_left = 0;
   logic [9:0]  paddr = 0;
   int          rd_lat = 2;
   logic        mem_off = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) mem[5] <= 16'h1234;
      if (mem_we) mem[mem_addr] <= mem_din;
      if (mem_nd && !mem_off) begin
         pend     <= 1'b1;
         lat_left <= rd_lat - 1;
         paddr    <= mem_addr;
      end else if (pend) begin
         if (lat_left == 0) pend <= 1'b0;
         else lat_left <= lat_left - 1;
      end
   end

   assign mem_rdy  = pend && (lat_left == 0);
   assign mem_dout = pend ? mem[paddr] : 16'h0000;

   sayeh_mem_arbiter #(
      .AW(10), .DW(16), .TIMEOUT(8), .FIXED_PRIO(0)
   ) dut (
      .clk(clk), .ExternalReset_n(rst_n),
      .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr),
      .p0_din(p0_din), .p0_dout(p0_dout), .p0_ready(p0_ready),
      .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr),
      .p1_din(p1_din), .p1_dout(p1_dout), .p1_ready(p1_ready),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_nd(mem_nd),
      .mem_we(mem_we), .mem_dout(mem_dout), .mem_rdy(mem_rdy),
      .busy(busy), .owner(owner), .timeout_err(timeout_err)
   );

   sayeh_mem_arbiter #(
      .AW(10), .DW(16), .TIMEOUT(8), .FIXED_PRIO(1)
   ) dut_fp (
      .clk(clk), .ExternalReset_n(rst_n),
      .p0_rd(1'b0), .p0_wr(f_p0_wr), .p0_addr(16'h0001),
      .p0_din(16'h1111), .p0_dout(f_p0_dout), .p0_ready(f_p0_ready),
      .p1_rd(1'b0), .p1_wr(f_p1_wr), .p1_addr(16'h0002),
      .p1_din(16'h2222), .p1_dout(f_p1_dout), .p1_ready(f_p1_ready),
      .mem_addr(f_mem_addr), .mem_din(f_mem_din), .mem_nd(f_mem_nd),
      .mem_we(f_mem_we), .mem_dout(16'h0000), .mem_rdy(1'b0),
      .busy(f_busy), .owner(f_owner), .timeout_err(f_terr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({busy, owner, mem_nd, mem_we, p0_ready, p1_ready, timeout_err}
          !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctl got=%b exp=0",
            {busy, owner, mem_nd, mem_we, p0_ready, p1_ready, timeout_err});
      end
      checks++;
      if ({p0_dout, p1_dout, mem_din, 6'b0, mem_addr} !== 64'h0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%h/%h exp=0",
            p0_dout, p1_dout, mem_din, mem_addr);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      rd_lat = 2;
      p0_rd = 1'b1;
      p0_addr = 16'h0005;
      tick();
      checks++;
      if (mem_nd !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h005) begin
         failures++;
         $display("FAIL sr_issue got nd=%b we=%b a=%h exp nd=1 we=0 a=005",
            mem_nd, mem_we, mem_addr);
      end
      tick();
      tick();
      checks++;
      if (p0_ready !== 1'b0 || mem_nd !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL sr_wait got rdy=%b nd=%b busy=%b exp 0 0 1",
            p0_ready, mem_nd, busy);
      end
      tick();
      checks++;
      if (p0_ready !== 1'b1 || p1_ready !== 1'b0 || p0_dout !== 16'h1234) begin
         failures++;
         $display("FAIL sr_done got r0=%b r1=%b d=%h exp 1 0 1234",
            p0_ready, p1_ready, p0_dout);
      end
      p0_rd = 1'b0;
      tick();
      checks++;
      if (p0_ready !== 1'b0 || busy !== 1'b0 || p0_dout !== 16'h1234) begin
         failures++;
         $display("FAIL sr_after got r0=%b busy=%b d=%h exp 0 0 1234",
            p0_ready, busy, p0_dout);
      end
   endtask

   task automatic test_write_read();
      p1_wr = 1'b1;
      p1_addr = 16'h03FF;
      p1_din = 16'hBEEF;
      tick();
      checks++;
      if (mem_we !== 1'b1 || mem_nd !== 1'b0 || mem_din !== 16'hBEEF
          || mem_addr !== 10'h3FF || owner !== 1'b1) begin
         failures++;
         $display("FAIL wr_issue got we=%b nd=%b d=%h a=%h o=%b exp 1 0 beef 3ff 1",
            mem_we, mem_nd, mem_din, mem_addr, owner);
      end
      tick();
      checks++;
      if (p1_ready !== 1'b1 || p0_ready !== 1'b0 || mem_we !== 1'b0) begin
         failures++;
         $display("FAIL wr_done got r1=%b r0=%b we=%b exp 1 0 0",
            p1_ready, p0_ready, mem_we);
      end
      p1_wr = 1'b0;
      tick();
      rd_lat = 1;
      p1_rd = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (p1_ready !== 1'b1 || p1_dout !== 16'hBEEF || p0_dout !== 16'h1234) begin
         failures++;
         $display("FAIL wr_readback got r1=%b d1=%h d0=%h exp 1 beef 1234",
            p1_ready, p1_dout, p0_dout);
      end
      p1_rd = 1'b0;
      tick();
   endtask

   task automatic test_contention();
      logic exp_o;
      rd_lat = 1;
      p0_rd = 1'b1;
      p0_addr = 16'h0005;
      p1_rd = 1'b1;
      p1_addr = 16'h03FF;
      for (int i = 0; i < 4; i++) begin
         exp_o = (i % 2) == 1;
         tick();
         checks++;
         if (owner !== exp_o || mem_nd !== 1'b1) begin
            failures++;
            $display("FAIL rr_grant%0d got o=%b nd=%b exp o=%b nd=1",
               i, owner, mem_nd, exp_o);
         end
         tick();
         tick();
         checks++;
         if ({p1_ready, p0_ready} !== (exp_o ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL rr_ready%0d got r1r0=%b%b exp_owner=%b",
               i, p1_ready, p0_ready, exp_o);
         end
         if (exp_o) p1_rd = 1'b0;
         else       p0_rd = 1'b0;
         tick();
         if (exp_o) p1_rd = 1'b1;
         else       p0_rd = 1'b1;
      end
      p0_rd = 1'b0;
      p1_rd = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      mem_off = 1'b1;
      p0_rd = 1'b1;
      p0_addr = 16'h0007;
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (busy !== 1'b1 || p0_ready !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL to_wait%0d got busy=%b r0=%b err=%b exp 1 0 0",
               i, busy, p0_ready, timeout_err);
         end
      end
      tick();
      checks++;
      if (p0_ready !== 1'b1 || p0_dout !== 16'hFFFF || timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL to_done got r0=%b d=%h err=%b exp 1 ffff 1",
            p0_ready, p0_dout, timeout_err);
      end
      p0_rd = 1'b0;
      mem_off = 1'b0;
      tick();
   endtask

   task automatic test_addr_trunc();
      p0_rd = 1'b1;
      p0_wr = 1'b1;
      p0_addr = 16'hFC12;
      p0_din = 16'h5A5A;
      tick();
      checks++;
      if (mem_we !== 1'b1 || mem_nd !== 1'b0 || mem_addr !== 10'h012
          || mem_din !== 16'h5A5A) begin
         failures++;
         $display("FAIL tr_issue got we=%b nd=%b a=%h d=%h exp 1 0 012 5a5a",
            mem_we, mem_nd, mem_addr, mem_din);
      end
      tick();
      checks++;
      if (p0_ready !== 1'b1 || mem_nd !== 1'b0 || p0_dout !== 16'hFFFF) begin
         failures++;
         $display("FAIL tr_done got r0=%b nd=%b d=%h exp 1 0 ffff",
            p0_ready, mem_nd, p0_dout);
      end
      p0_rd = 1'b0;
      p0_wr = 1'b0;
      tick();
      checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL tr_sticky got err=%b busy=%b exp 1 0",
            timeout_err, busy);
      end
   endtask

   task automatic test_reset_mid_read();
      rd_lat = 3;
      p1_rd = 1'b1;
      p1_addr = 16'h03FF;
      tick();
      tick();
      rst_n = 1'b0;
      p1_rd = 1'b0;
      tick();
      checks++;
      if ({busy, owner, timeout_err, p1_ready, mem_nd} !== 5'b0
          || p1_dout !== 16'h0 || p0_dout !== 16'h0) begin
         failures++;
         $display("FAIL rst_mid got b/o/e/r1/nd=%b d1=%h d0=%h exp 0",
            {busy, owner, timeout_err, p1_ready, mem_nd}, p1_dout, p0_dout);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (p1_ready !== 1'b0 || p0_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_late_rdy got r1=%b r0=%b busy=%b exp 0 0 0",
            p1_ready, p0_ready, busy);
      end
      tick();
      checks++;
      if (p1_ready !== 1'b0 || p1_dout !== 16'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_after got r1=%b d1=%h busy=%b exp 0 0 0",
            p1_ready, p1_dout, busy);
      end
   endtask

   task automatic test_fixed_prio();
      f_p0_wr = 1'b1;
      tick();
      tick();
      checks++;
      if (f_p0_ready !== 1'b1 || f_owner !== 1'b0) begin
         failures++;
         $display("FAIL fp_solo got r0=%b o=%b exp 1 0", f_p0_ready, f_owner);
      end
      f_p0_wr = 1'b0;
      tick();
      f_p0_wr = 1'b1;
      f_p1_wr = 1'b1;
      tick();
      checks++;
      if (f_owner !== 1'b0 || f_mem_we !== 1'b1 || f_mem_addr !== 10'h001) begin
         failures++;
         $display("FAIL fp_tie got o=%b we=%b a=%h exp 0 1 001",
            f_owner, f_mem_we, f_mem_addr);
      end
      tick();
      checks++;
      if (f_p0_ready !== 1'b1 || f_p1_ready !== 1'b0) begin
         failures++;
         $display("FAIL fp_tie_done got r0=%b r1=%b exp 1 0",
            f_p0_ready, f_p1_ready);
      end
      f_p0_wr = 1'b0;
      tick();
      tick();
      checks++;
      if (f_owner !== 1'b1 || f_mem_din !== 16'h2222) begin
         failures++;
         $display("FAIL fp_second got o=%b d=%h exp 1 2222",
            f_owner, f_mem_din);
      end
      tick();
      checks++;
      if (f_p1_ready !== 1'b1 || f_p0_ready !== 1'b0) begin
         failures++;
         $display("FAIL fp_second_done got r1=%b r0=%b exp 1 0",
            f_p1_ready, f_p0_ready);
      end
      f_p1_wr = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_timeout();
      test_addr_trunc();
      test_reset_mid_read();
      test_fixed_prio();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
